// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared constants for the pipeline hazard scoreboard.
//
// Holds the forwarding-select encodings driven on fwd_a_e / fwd_b_e, the
// "operand not read" Tuse marker, and the Tnew/Tuse values each instruction
// class decodes to. The Tnew/Tuse constants are written at the default
// T_W of 2 bits; the scoreboard itself derives its own all-ones marker from
// T_W so it stays correct when T_W is widened.
//
// Ports: none (package).
package hazard_pkg;

    // Forwarding selects for the E-stage ALU operands.
    localparam logic [1:0] FWD_RF = 2'b00;  // register file value
    localparam logic [1:0] FWD_M  = 2'b01;  // M-stage result
    localparam logic [1:0] FWD_W  = 2'b10;  // W-stage result

    // All-ones Tuse: the D instruction does not read that operand.
    localparam logic [1:0] TUSE_NONE   = 2'b11;

    // Tuse per instruction class (cycles until the value is consumed).
    localparam logic [1:0] TUSE_BRANCH = 2'b00;  // compared in D
    localparam logic [1:0] TUSE_ALU    = 2'b01;  // consumed in E
    localparam logic [1:0] TUSE_STORE  = 2'b10;  // store data consumed in M

    // Tnew per instruction class, as seen while the producer sits in E.
    localparam logic [1:0] TNEW_NONE   = 2'b00;  // no result / bubble
    localparam logic [1:0] TNEW_ALU    = 2'b01;  // ready at end of E
    localparam logic [1:0] TNEW_LOAD   = 2'b10;  // ready at end of M

    function automatic int lat_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// md_busy_ctr -- busy counter for the iterative multiply/divide unit.
//
// A start loads MUL_LAT or DIV_LAT; the count then falls by one each clock
// and parks at zero. busy is high while the count is non-zero, so a started
// operation reports busy for exactly MUL_LAT / DIV_LAT cycles. A start that
// arrives while busy is dropped and the running count carries on.
//
// Ports:
//   clk    in  clock
//   reset  in  asynchronous active-high reset (aborts any operation)
//   start  in  launch an operation this cycle
//   is_div in  1 = divide, 0 = multiply (sampled with start)
//   busy   out operation in progress
module md_busy_ctr
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int CW = $clog2(lat_max(MUL_LAT, DIV_LAT) + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (start && (cnt == '0)) begin
            cnt <= is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign busy = (cnt != '0);

    // The decoder must never issue a new mult/div while one is running.
    a_no_start_while_busy: assert property (
        @(posedge clk) disable iff (reset) !(start && busy)
    );

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard -- Tnew/Tuse stall and forwarding control for a
// five-stage D/E/M/W pipeline.
//
// The only state is tnew_m (the remaining Tnew of the instruction now in M)
// and, when HAZARD_MD_EN is defined, the mult/div busy counter. Stall and
// all forwarding selects are combinational from the current inputs. The
// registers are never held on stall: the surrounding pipeline turns a
// stalled E slot into a bubble (E_regwrite=0, E_tnew=0).
//
// Configuration macro: HAZARD_MD_EN -- adds the mult/div busy counter and
// its D-stage stall. Without it md_busy is 0 and E_md_start, E_md_div and
// D_is_md are ignored.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   D_rs, D_rt, D_tuse_rs/_rt     D-stage sources and their Tuse
//   D_is_md                       D instruction touches mult/div/HI/LO
//   E_rs, E_rt, E_wra, E_regwrite E-stage sources and destination
//   E_tnew                        Tnew of the E instruction
//   E_md_start, E_md_div          launch mult (0) / div (1) from E
//   M_rt, M_wra, M_regwrite       M-stage store-data source and destination
//   W_wra, W_regwrite             W-stage destination
//   stall                         hold F/D, bubble E
//   fwd_rs_d, fwd_rt_d            D comparator takes the M result
//   fwd_a_e, fwd_b_e              E operand select (FWD_RF/FWD_M/FWD_W)
//   fwd_m                         M store data takes the W result
//   md_busy                       mult/div unit busy
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int T_W     = 2,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] D_rs,
    input  logic [REG_AW-1:0] D_rt,
    input  logic [T_W-1:0]    D_tuse_rs,
    input  logic [T_W-1:0]    D_tuse_rt,
    input  logic              D_is_md,
    input  logic [REG_AW-1:0] E_rs,
    input  logic [REG_AW-1:0] E_rt,
    input  logic [REG_AW-1:0] E_wra,
    input  logic              E_regwrite,
    input  logic [T_W-1:0]    E_tnew,
    input  logic              E_md_start,
    input  logic              E_md_div,
    input  logic [REG_AW-1:0] M_rt,
    input  logic [REG_AW-1:0] M_wra,
    input  logic              M_regwrite,
    input  logic [REG_AW-1:0] W_wra,
    input  logic              W_regwrite,
    output logic              stall,
    output logic              fwd_rs_d,
    output logic              fwd_rt_d,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              fwd_m,
    output logic              md_busy
);

    localparam logic [T_W-1:0] TUSE_OFF = {T_W{1'b1}};

    // Register 0 is hard-wired, so it never produces a hazard.
    function automatic logic hit(input logic [REG_AW-1:0] src,
                                 input logic [REG_AW-1:0] wra,
                                 input logic              we);
        return (src != '0) && we && (src == wra);
    endfunction

    // Remaining Tnew of the instruction now in M: one cycle less than it
    // had in E, floored at zero. Loaded every edge; a bubble brings 0.
    logic [T_W-1:0] tnew_m;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tnew_m <= '0;
        end else begin
            tnew_m <= (E_tnew == '0) ? '0 : E_tnew - T_W'(1);
        end
    end

    logic rs_hit_e, rs_hit_m, rt_hit_e, rt_hit_m;
    logic rs_stall, rt_stall, data_stall;

    assign rs_hit_e = hit(D_rs, E_wra, E_regwrite);
    assign rs_hit_m = hit(D_rs, M_wra, M_regwrite);
    assign rt_hit_e = hit(D_rt, E_wra, E_regwrite);
    assign rt_hit_m = hit(D_rt, M_wra, M_regwrite);

    // A producer stalls the consumer only if its value arrives later than
    // the consumer needs it.
    assign rs_stall = (D_tuse_rs != TUSE_OFF) &&
                      ((rs_hit_e && (E_tnew > D_tuse_rs)) ||
                       (rs_hit_m && (tnew_m > D_tuse_rs)));
    assign rt_stall = (D_tuse_rt != TUSE_OFF) &&
                      ((rt_hit_e && (E_tnew > D_tuse_rt)) ||
                       (rt_hit_m && (tnew_m > D_tuse_rt)));
    assign data_stall = rs_stall || rt_stall;

    // D-stage forwarding: only a finished M result can feed the comparator.
    assign fwd_rs_d = rs_hit_m && (tnew_m == '0);
    assign fwd_rt_d = rt_hit_m && (tnew_m == '0);

    // E-stage operand selects; the younger M result wins over W.
    always_comb begin
        fwd_a_e = FWD_RF;
        if (hit(E_rs, M_wra, M_regwrite) && (tnew_m == '0)) begin
            fwd_a_e = FWD_M;
        end else if (hit(E_rs, W_wra, W_regwrite)) begin
            fwd_a_e = FWD_W;
        end
    end

    always_comb begin
        fwd_b_e = FWD_RF;
        if (hit(E_rt, M_wra, M_regwrite) && (tnew_m == '0)) begin
            fwd_b_e = FWD_M;
        end else if (hit(E_rt, W_wra, W_regwrite)) begin
            fwd_b_e = FWD_W;
        end
    end

    // Store data in M picks up a result being written back this cycle.
    assign fwd_m = hit(M_rt, W_wra, W_regwrite);

`ifdef HAZARD_MD_EN
    md_busy_ctr #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_busy_ctr (
        .clk    (clk),
        .reset  (reset),
        .start  (E_md_start),
        .is_div (E_md_div),
        .busy   (md_busy)
    );

    // A start in E is not yet visible as busy, so it stalls too.
    logic md_stall;
    assign md_stall = D_is_md && (md_busy || E_md_start);
    assign stall    = data_stall || md_stall;
`else
    logic md_inputs_unused;
    assign md_inputs_unused = ^{E_md_start, E_md_div, D_is_md};
    assign md_busy = 1'b0;
    assign stall   = data_stall;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard -- directed vector bench for hazard_scoreboard.
// Output checks are packed as {stall, fwd_rs_d, fwd_rt_d, fwd_a_e,
// fwd_b_e, fwd_m, md_busy}. Compiles with or without HAZARD_MD_EN.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

`ifdef HAZARD_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [4:0] D_rs, D_rt, E_rs, E_rt, E_wra, M_rt, M_wra, W_wra;
    logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew;
    logic       D_is_md, E_regwrite, E_md_start, E_md_div, M_regwrite, W_regwrite;
    logic       stall, fwd_rs_d, fwd_rt_d, fwd_m, md_busy;
    logic [1:0] fwd_a_e, fwd_b_e;

    hazard_scoreboard #(
        .REG_AW (5), .T_W (2), .MUL_LAT (5), .DIV_LAT (10)
    ) dut (
        .clk (clk), .reset (reset),
        .D_rs (D_rs), .D_rt (D_rt), .D_tuse_rs (D_tuse_rs), .D_tuse_rt (D_tuse_rt),
        .D_is_md (D_is_md),
        .E_rs (E_rs), .E_rt (E_rt), .E_wra (E_wra), .E_regwrite (E_regwrite),
        .E_tnew (E_tnew), .E_md_start (E_md_start), .E_md_div (E_md_div),
        .M_rt (M_rt), .M_wra (M_wra), .M_regwrite (M_regwrite),
        .W_wra (W_wra), .W_regwrite (W_regwrite),
        .stall (stall), .fwd_rs_d (fwd_rs_d), .fwd_rt_d (fwd_rt_d),
        .fwd_a_e (fwd_a_e), .fwd_b_e (fwd_b_e), .fwd_m (fwd_m), .md_busy (md_busy)
    );

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [8:0] mk(input logic st, input logic rsd, input logic rtd,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic fm, input logic busy);
        return {st, rsd, rtd, a, b, fm, busy};
    endfunction

    task automatic check_out(input string name, input logic [8:0] expv);
        logic [8:0] act;
        logic [8:0] want;
        exp_q.push_back(expv);
        act  = {stall, fwd_rs_d, fwd_rt_d, fwd_a_e, fwd_b_e, fwd_m, md_busy};
        want = exp_q.pop_front();
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %b required %b (stall,rsd,rtd,a,b,fm,busy)",
                     name, act, want);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        D_rs = 0; D_rt = 0; D_tuse_rs = TUSE_NONE; D_tuse_rt = TUSE_NONE; D_is_md = 0;
        E_rs = 0; E_rt = 0; E_wra = 0; E_regwrite = 0; E_tnew = TNEW_NONE;
        E_md_start = 0; E_md_div = 0;
        M_rt = 0; M_wra = 0; M_regwrite = 0; W_wra = 0; W_regwrite = 0;
    endtask

    typedef struct {
        string      name;
        logic [1:0] pre_tnew;   // E_tnew at the preceding edge -> sets tnew_m
        logic [4:0] d_rs, d_rt;
        logic [1:0] tuse_rs, tuse_rt;
        logic [4:0] e_rs, e_rt, e_wra;
        logic       e_rw;
        logic [1:0] e_tnew;
        logic [4:0] m_rt, m_wra;
        logic       m_rw;
        logic [4:0] w_wra;
        logic       w_rw;
        logic [8:0] expv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t idle_vec(input string name, input logic [1:0] pre);
        vec_t v;
        v.name = name; v.pre_tnew = pre;
        v.d_rs = 0; v.d_rt = 0; v.tuse_rs = TUSE_NONE; v.tuse_rt = TUSE_NONE;
        v.e_rs = 0; v.e_rt = 0; v.e_wra = 0; v.e_rw = 0; v.e_tnew = 0;
        v.m_rt = 0; v.m_wra = 0; v.m_rw = 0; v.w_wra = 0; v.w_rw = 0;
        v.expv = '0;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        drive_idle();
        E_tnew = v.pre_tnew;
        @(posedge clk);
        #1;
        D_rs = v.d_rs; D_rt = v.d_rt; D_tuse_rs = v.tuse_rs; D_tuse_rt = v.tuse_rt;
        E_rs = v.e_rs; E_rt = v.e_rt; E_wra = v.e_wra; E_regwrite = v.e_rw; E_tnew = v.e_tnew;
        M_rt = v.m_rt; M_wra = v.m_wra; M_regwrite = v.m_rw;
        W_wra = v.w_wra; W_regwrite = v.w_rw;
        #1;
        check_out(v.name, v.expv);
    endtask

    task automatic build_table();
        vec_t v;
        v = idle_vec("idle", 0);                                      vecs.push_back(v);
        v = idle_vec("e_hit_stall", 0); v.d_rs = 8; v.tuse_rs = 1; v.e_wra = 8; v.e_rw = 1; v.e_tnew = 2;
        v.expv = mk(1,0,0,FWD_RF,FWD_RF,0,0);                         vecs.push_back(v);
        v = idle_vec("e_hit_tnew_eq_tuse", 0); v.d_rs = 8; v.tuse_rs = 1; v.e_wra = 8; v.e_rw = 1; v.e_tnew = 1;
        vecs.push_back(v);
        v = idle_vec("tuse_none", 0); v.d_rs = 8; v.tuse_rs = TUSE_NONE; v.e_wra = 8; v.e_rw = 1; v.e_tnew = 3;
        vecs.push_back(v);
        v = idle_vec("r0_no_hit", 0); v.tuse_rs = 0; v.e_rw = 1; v.e_tnew = 2;
        vecs.push_back(v);
        v = idle_vec("e_hit_no_regwrite", 0); v.d_rs = 8; v.tuse_rs = 0; v.e_wra = 8; v.e_tnew = 2;
        vecs.push_back(v);
        v = idle_vec("m_hit_stall", 3); v.d_rt = 7; v.tuse_rt = 1; v.m_wra = 7; v.m_rw = 1;
        v.expv = mk(1,0,0,FWD_RF,FWD_RF,0,0);                         vecs.push_back(v);
        v = idle_vec("m_tnew1_tuse1", 2); v.d_rt = 7; v.tuse_rt = 1; v.m_wra = 7; v.m_rw = 1;
        vecs.push_back(v);
        v = idle_vec("m_fwd_rs_d", 1); v.d_rs = 7; v.tuse_rs = 0; v.m_wra = 7; v.m_rw = 1;
        v.expv = mk(0,1,0,FWD_RF,FWD_RF,0,0);                         vecs.push_back(v);
        v = idle_vec("tnew_floor_fwd_rt_d", 0); v.d_rt = 7; v.tuse_rt = 0; v.m_wra = 7; v.m_rw = 1;
        v.expv = mk(0,0,1,FWD_RF,FWD_RF,0,0);                         vecs.push_back(v);
        v = idle_vec("m_no_regwrite", 1); v.d_rs = 7; v.tuse_rs = 0; v.m_wra = 7;
        vecs.push_back(v);
        v = idle_vec("fwd_a_m_b_w", 1); v.e_rs = 4; v.e_rt = 5; v.m_wra = 4; v.m_rw = 1; v.w_wra = 5; v.w_rw = 1;
        v.expv = mk(0,0,0,FWD_M,FWD_W,0,0);                           vecs.push_back(v);
        v = idle_vec("fwd_ab_w", 0); v.e_rs = 6; v.e_rt = 6; v.w_wra = 6; v.w_rw = 1;
        v.expv = mk(0,0,0,FWD_W,FWD_W,0,0);                           vecs.push_back(v);
        v = idle_vec("m_not_ready_w_wins", 2); v.e_rs = 4; v.m_wra = 4; v.m_rw = 1; v.w_wra = 4; v.w_rw = 1;
        v.expv = mk(0,0,0,FWD_W,FWD_RF,0,0);                          vecs.push_back(v);
        v = idle_vec("fwd_m", 0); v.m_rt = 3; v.w_wra = 3; v.w_rw = 1;
        v.expv = mk(0,0,0,FWD_RF,FWD_RF,1,0);                         vecs.push_back(v);
        v = idle_vec("fwd_m_r0", 0); v.w_rw = 1;                      vecs.push_back(v);
        v = idle_vec("rt_stall_rs_none", 0); v.d_rs = 2; v.d_rt = 2; v.tuse_rt = 0;
        v.e_wra = 2; v.e_rw = 1; v.e_tnew = 1;
        v.expv = mk(1,0,0,FWD_RF,FWD_RF,0,0);                         vecs.push_back(v);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        drive_idle();
        #12;
        check_out("reset_state", mk(0,0,0,FWD_RF,FWD_RF,0,0));
        @(negedge clk);
        reset = 1'b0;

        build_table();
        foreach (vecs[i]) apply_vec(vecs[i]);

        // Load-use into a branch compare: two stall cycles, then M forward.
        @(negedge clk);
        drive_idle();
        E_wra = 8; E_regwrite = 1; E_tnew = TNEW_LOAD; D_rs = 8; D_tuse_rs = TUSE_BRANCH;
        #1 check_out("lu_e", mk(1,0,0,FWD_RF,FWD_RF,0,0));
        @(posedge clk);
        #1;
        E_wra = 0; E_regwrite = 0; E_tnew = TNEW_NONE; M_wra = 8; M_regwrite = 1;
        #1 check_out("lu_m_tnew1", mk(1,0,0,FWD_RF,FWD_RF,0,0));
        @(posedge clk);
        #2 check_out("lu_m_tnew0", mk(0,1,0,FWD_RF,FWD_RF,0,0));

        // ALU result into beq: one stall cycle, then M forward.
        @(negedge clk);
        drive_idle();
        E_wra = 9; E_regwrite = 1; E_tnew = TNEW_ALU; D_rt = 9; D_tuse_rt = TUSE_BRANCH;
        #1 check_out("alu_beq_e", mk(1,0,0,FWD_RF,FWD_RF,0,0));
        @(posedge clk);
        #1;
        E_wra = 0; E_regwrite = 0; E_tnew = TNEW_NONE; M_wra = 9; M_regwrite = 1;
        #1 check_out("alu_beq_m", mk(0,0,1,FWD_RF,FWD_RF,0,0));

        // Double hit on E_rs.
        @(negedge clk);
        drive_idle();
        E_rs = 4; M_wra = 4; M_regwrite = 1; W_wra = 4; W_regwrite = 1;
        #1 check_out("dbl_m", mk(0,0,0,FWD_M,FWD_RF,0,0));
        M_regwrite = 0;
        #1 check_out("dbl_w", mk(0,0,0,FWD_W,FWD_RF,0,0));
        E_rs = 0;
        #1 check_out("dbl_r0", mk(0,0,0,FWD_RF,FWD_RF,0,0));

        // Multiply with no md consumer in D: busy 5 cycles, never stalls.
        @(negedge clk);
        drive_idle();
        E_md_start = 1; E_md_div = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) E_md_start = 0;
            check_out($sformatf("mul_c%0d", i), mk(0,0,0,FWD_RF,FWD_RF,0, MD_EN && (i < 5)));
        end

        // Divide with an md consumer waiting in D.
        @(negedge clk);
        drive_idle();
        E_md_start = 1; E_md_div = 1; D_is_md = 1;
        #1 check_out("div_start", mk(MD_EN,0,0,FWD_RF,FWD_RF,0,0));
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) E_md_start = 0;
            check_out($sformatf("div_c%0d", i),
                      mk(MD_EN && (i < 10),0,0,FWD_RF,FWD_RF,0, MD_EN && (i < 10)));
        end

        // Reset in the third busy cycle of a divide, with tnew_m held at 2.
        @(negedge clk);
        drive_idle();
        E_md_start = 1; E_md_div = 1; D_is_md = 1; E_tnew = 3;
        D_rs = 8; D_tuse_rs = TUSE_ALU; M_wra = 8; M_regwrite = 1;
        @(posedge clk);
        #1 E_md_start = 0;
        @(posedge clk);
        @(posedge clk);
        #2 check_out("rst_pre", mk(1,0,0,FWD_RF,FWD_RF,0,MD_EN));
        reset = 1'b1;
        #1 check_out("rst_async", mk(0,1,0,FWD_RF,FWD_RF,0,0));
        @(negedge clk);
        reset = 1'b0; E_tnew = 0;
        #1 check_out("rst_release", mk(0,1,0,FWD_RF,FWD_RF,0,0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check_out($sformatf("rst_after_c%0d", i), mk(0,1,0,FWD_RF,FWD_RF,0,0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
